csr_counter_bank: RTL and testbench

Parametrised bank of machine hardware performance counters (mcycle, minstret and mhpmcounterN generalised) sitting behind the CSR unit. It supersedes fixed 33–64-bit cycle/instret counters with N independent channels of configurable width. Each channel has multi-increment per cycle (for multi-port retire), a per-channel inhibit, a per-channel writeability mask and a split 32-bit CSR access path.

---
 rtl/csr_counter_bank.sv | 116 +++++++++++
 tb/tb_csr_counter_bank.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/csr_counter_bank.sv
// csr_counter_bank: bank of NUM_COUNTERS hardware performance counters with
// multi-increment per cycle, per-channel inhibit, per-channel write mask and a
// split 32-bit CSR read/write path.
// Optional feature: define COUNTER_OVERFLOW_EN to implement sticky wrap flags;
// without it the overflow output is tied to 0 and counters still wrap modulo
// 2^COUNTER_W.
module csr_counter_bank #(
  parameter int NUM_COUNTERS = 3,
  parameter int COUNTER_W    = 48,
  parameter int INC_W        = 2,
  parameter logic [NUM_COUNTERS-1:0] WRITEABLE_MASK = '1
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [NUM_COUNTERS*INC_W-1:0]   inc,
  input  logic                            inhibit_we,
  input  logic [NUM_COUNTERS-1:0]         inhibit_wdata,
  output logic [NUM_COUNTERS-1:0]         inhibit,
  input  logic [4:0]                      csr_sel,
  input  logic                            csr_hi,
  input  logic                            csr_re,
  input  logic                            csr_we,
  input  logic [31:0]                     csr_wdata,
  output logic [31:0]                     csr_rdata,
  output logic                            csr_rvalid,
  output logic [NUM_COUNTERS-1:0]         overflow
);

  logic [NUM_COUNTERS-1:0][COUNTER_W-1:0] count;
  logic [NUM_COUNTERS-1:0][COUNTER_W-1:0] count_nxt;
  logic [NUM_COUNTERS-1:0]                wr_hit;
  logic [NUM_COUNTERS-1:0]                wrap;
  logic [31:0]                            rd_mux;

  // Per-channel next count: an accepted CSR write wins over the increment,
  // otherwise count += inc unless inhibited (old inhibit applies this cycle).
  always_comb begin
    logic [COUNTER_W:0] sum;
    sum       = '0;
    count_nxt = count;
    wr_hit    = '0;
    wrap      = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      wr_hit[i] = csr_we && WRITEABLE_MASK[i] && (csr_sel == 5'(i));
      sum = {1'b0, count[i]} +
            {{(COUNTER_W + 1 - INC_W){1'b0}}, inc[i*INC_W +: INC_W]};
      if (wr_hit[i]) begin
        if (csr_hi)
          count_nxt[i][COUNTER_W-1:32] = csr_wdata[COUNTER_W-33:0];
        else
          count_nxt[i][31:0] = csr_wdata;
      end else if (!inhibit[i]) begin
        count_nxt[i] = sum[COUNTER_W-1:0];
        wrap[i]      = sum[COUNTER_W];
      end
    end
  end

  // Read mux on the pre-update count; out-of-range selects return zero and
  // the upper half is zero-extended above COUNTER_W.
  always_comb begin
    logic [31:0] hi_ext;
    hi_ext = '0;
    rd_mux = '0;
    for (int i = 0; i < NUM_COUNTERS; i++) begin
      if (csr_sel == 5'(i)) begin
        hi_ext = '0;
        hi_ext[COUNTER_W-33:0] = count[i][COUNTER_W-1:32];
        rd_mux = csr_hi ? hi_ext : count[i][31:0];
      end
    end
  end

  // Counter and inhibit state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count   <= '0;
      inhibit <= '0;
    end else begin
      count <= count_nxt;
      if (inhibit_we)
        inhibit <= inhibit_wdata;
    end
  end

  // Registered read response; rvalid is a one-cycle pulse per request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csr_rdata  <= '0;
      csr_rvalid <= 1'b0;
    end else begin
      csr_rvalid <= csr_re;
      if (csr_re)
        csr_rdata <= rd_mux;
    end
  end

`ifdef COUNTER_OVERFLOW_EN
  logic [NUM_COUNTERS-1:0] ovf;

  // Sticky wrap flags; an accepted write to the channel clears and beats a set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      ovf <= '0;
    else
      ovf <= (ovf | wrap) & ~wr_hit;
  end

  assign overflow = ovf;
`else
  logic unused_wrap;
  assign unused_wrap = ^wrap;
  assign overflow    = '0;
`endif

endmodule

// File: tb/tb_csr_counter_bank.sv
// Scoreboard bench for csr_counter_bank (3 channels, 48-bit, mask 3'b101).
module tb_csr_counter_bank;
  localparam int N  = 3;
  localparam int CW = 48;
  localparam int IW = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic [N*IW-1:0] inc;
  logic          inhibit_we;
  logic [N-1:0]  inhibit_wdata;
  logic [N-1:0]  inhibit;
  logic [4:0]    csr_sel;
  logic          csr_hi;
  logic          csr_re;
  logic          csr_we;
  logic [31:0]   csr_wdata;
  logic [31:0]   csr_rdata;
  logic          csr_rvalid;
  logic [N-1:0]  overflow;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q[$];

`ifdef COUNTER_OVERFLOW_EN
  localparam logic OVF_ON = 1'b1;
`else
  localparam logic OVF_ON = 1'b0;
`endif

  csr_counter_bank #(
    .NUM_COUNTERS(N),
    .COUNTER_W(CW),
    .INC_W(IW),
    .WRITEABLE_MASK(3'b101)
  ) dut (
    .clk(clk),
    .rst(rst),
    .inc(inc),
    .inhibit_we(inhibit_we),
    .inhibit_wdata(inhibit_wdata),
    .inhibit(inhibit),
    .csr_sel(csr_sel),
    .csr_hi(csr_hi),
    .csr_re(csr_re),
    .csr_we(csr_we),
    .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .csr_rvalid(csr_rvalid),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: pops one expected value per read response.
  always @(negedge clk) begin
    if (csr_rvalid === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_rvalid: rdata 0x%0h with no outstanding read", csr_rdata);
      end else begin
        check("csr_rdata", {32'h0, csr_rdata}, {32'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_inc(input logic [1:0] i0, input logic [1:0] i1, input logic [1:0] i2);
    inc = {i2, i1, i0};
  endtask

  task automatic rd(input logic [4:0] sel, input logic hi, input logic [31:0] exp);
    csr_sel = sel;
    csr_hi  = hi;
    csr_re  = 1'b1;
    exp_q.push_back(exp);
    step();
    csr_re = 1'b0;
  endtask

  task automatic wr(input logic [4:0] sel, input logic hi, input logic [31:0] data);
    csr_sel   = sel;
    csr_hi    = hi;
    csr_wdata = data;
    csr_we    = 1'b1;
    step();
    csr_we = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    set_inc(2'd1, 2'd1, 2'd1);
    inhibit_we = 1'b0;
    inhibit_wdata = '0;
    csr_sel = '0;
    csr_hi = 1'b0;
    csr_re = 1'b0;
    csr_we = 1'b0;
    csr_wdata = '0;

    // Outputs held at zero during reset, even with increments requested.
    step();
    step();
    check("reset_inhibit", {61'h0, inhibit}, 64'h0);
    check("reset_overflow", {61'h0, overflow}, 64'h0);
    check("reset_rvalid", {63'h0, csr_rvalid}, 64'h0);
    check("reset_rdata", {32'h0, csr_rdata}, 64'h0);

    // Release reset and count 10 cycles on every channel.
    rst = 1'b0;
    repeat (10) step();
    set_inc(2'd0, 2'd0, 2'd0);
    rd(5'd0, 1'b0, 32'd10);
    rd(5'd0, 1'b1, 32'd0);

    // Multi-increment on ch2: 3,3,3,3,2 from zero.
    wr(5'd2, 1'b0, 32'd0);
    set_inc(2'd0, 2'd0, 2'd3);
    repeat (4) step();
    set_inc(2'd0, 2'd0, 2'd2);
    step();
    set_inc(2'd0, 2'd0, 2'd0);
    rd(5'd2, 1'b0, 32'd14);

    // Split write: excess upper wdata bits dropped.
    wr(5'd0, 1'b1, 32'hFFFF_1234);
    wr(5'd0, 1'b0, 32'hFFFF_FFFE);
    rd(5'd0, 1'b1, 32'h0000_1234);
    rd(5'd0, 1'b0, 32'hFFFF_FFFE);

    // Wrap: 2^48-2 + 3 = 1 modulo 2^48.
    wr(5'd0, 1'b1, 32'h0000_FFFF);
    check("ovf_before_wrap", {61'h0, overflow}, 64'h0);
    set_inc(2'd3, 2'd0, 2'd0);
    step();
    set_inc(2'd0, 2'd0, 2'd0);
    check("ovf_after_wrap", {61'h0, overflow}, {61'h0, 2'b00, OVF_ON});
    rd(5'd0, 1'b0, 32'd1);
    rd(5'd0, 1'b1, 32'd0);
    check("ovf_sticky", {61'h0, overflow}, {61'h0, 2'b00, OVF_ON});
    wr(5'd0, 1'b0, 32'd0);
    check("ovf_cleared", {61'h0, overflow}, 64'h0);
    rd(5'd0, 1'b0, 32'd0);

    // Collision: write beats the same-cycle increment.
    set_inc(2'd0, 2'd0, 2'd2);
    wr(5'd2, 1'b0, 32'd100);
    set_inc(2'd0, 2'd0, 2'd0);
    rd(5'd2, 1'b0, 32'd100);
    // Read and write together: read returns the pre-write value.
    csr_wdata = 32'd300;
    csr_we = 1'b1;
    rd(5'd2, 1'b0, 32'd100);
    csr_we = 1'b0;
    rd(5'd2, 1'b0, 32'd300);

    // Masked channel 1 ignores writes (still holds 10).
    wr(5'd1, 1'b0, 32'd555);
    rd(5'd1, 1'b0, 32'd10);

    // Inhibit ch0: the write-cycle increment uses the old inhibit, then 5 held cycles.
    set_inc(2'd1, 2'd0, 2'd0);
    inhibit_wdata = 3'b001;
    inhibit_we = 1'b1;
    step();
    inhibit_we = 1'b0;
    check("inhibit_out", {61'h0, inhibit}, 64'h1);
    repeat (5) step();
    set_inc(2'd0, 2'd0, 2'd0);
    rd(5'd0, 1'b0, 32'd1);
    inhibit_wdata = 3'b000;
    inhibit_we = 1'b1;
    step();
    inhibit_we = 1'b0;
    check("inhibit_cleared", {61'h0, inhibit}, 64'h0);

    // Out-of-range selects read zero with rvalid.
    rd(5'd7, 1'b0, 32'd0);
    rd(5'd3, 1'b1, 32'd0);

    // Reset asserted while a read response is pending drops it.
    repeat (2) step();
    check("queue_drained", 64'(exp_q.size()), 64'h0);
    csr_sel = 5'd2;
    csr_hi = 1'b0;
    csr_re = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    csr_re = 1'b0;
    #1;
    check("rst_drops_rvalid", {63'h0, csr_rvalid}, 64'h0);
    check("rst_clears_rdata", {32'h0, csr_rdata}, 64'h0);
    step();
    rst = 1'b0;
    rd(5'd2, 1'b0, 32'd0);
    repeat (2) step();
    check("final_queue_drained", 64'(exp_q.size()), 64'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
